// File: rtl/mpsub_pkg.sv
// mpsub_pkg: shared sizes and state encoding for the word-serial subtractor.
package mpsub_pkg;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;
    localparam int W         = WORD_W * NUM_WORDS;
    localparam int IDX_W     = $clog2(NUM_WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mpsub_limb.sv
// mpsub_limb: one-limb subtract with borrow in/out, d = a - b - bin.
import mpsub_pkg::*;

module mpsub_limb (
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              bin,
    output logic [WORD_W-1:0] d,
    output logic              bout
);
    // The extra top bit of the wide difference is the borrow out.
    assign {bout, d} = {1'b0, a} - {1'b0, b} - {{WORD_W{1'b0}}, bin};
endmodule

// File: rtl/mpsub32_serial.sv
// mpsub32_serial: 256-bit subtractor, one 32-bit limb per cycle, LS limb first,
// with borrow and equality flags for modular-reduction control.
import mpsub_pkg::*;

module mpsub32_serial (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         write,
    input  logic         start,
    output logic         busy,
    output logic         ready,
    output logic [W-1:0] d_out,
    output logic         borrow_out,
    output logic         zero_out
);
    state_t             state, state_next;
    logic [W-1:0]       a_sr, b_sr;
    logic [IDX_W-1:0]   idx;
    logic               brw, acc, bout, last;
    logic [WORD_W-1:0]  d_k;

    mpsub_limb u_limb (
        .a    (a_sr[WORD_W-1:0]),
        .b    (b_sr[WORD_W-1:0]),
        .bin  (brw),
        .d    (d_k),
        .bout (bout)
    );

    assign last = idx == IDX_W'(NUM_WORDS - 1);

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = (state == IDLE) ? (start ? RUN : IDLE)
                   : (state == RUN)  ? (last ? DONE : RUN)
                   : IDLE;
    end

    always_comb begin
        busy  = state == RUN;
        ready = state == DONE;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a_sr       <= '0;
            b_sr       <= '0;
            d_out      <= '0;
            idx        <= '0;
            brw        <= 1'b0;
            acc        <= 1'b0;
            borrow_out <= 1'b0;
            zero_out   <= 1'b0;
        end else if (state == IDLE) begin
            if (write) begin
                a_sr <= a_in;
                b_sr <= b_in;
            end
            if (start) begin
                idx   <= '0;
                brw   <= 1'b0;
                acc   <= 1'b0;
                d_out <= '0;
            end
        end else if (state == RUN) begin
            d_out[idx*WORD_W +: WORD_W] <= d_k;
            brw  <= bout;
            acc  <= acc | (|d_k);
            a_sr <= a_sr >> WORD_W;
            b_sr <= b_sr >> WORD_W;
            idx  <= idx + 1'b1;
            if (last) begin
                borrow_out <= bout;
                zero_out   <= ~(acc | (|d_k));
            end
        end
    end
endmodule

// File: tb/tb_mpsub32_serial.sv
// tb_mpsub32_serial: directed vector table plus handshake and mid-run reset sequences.
module tb_mpsub32_serial;
    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [255:0] a_in = '0, b_in = '0;
    logic         write = 1'b0, start = 1'b0;
    logic         busy, ready, borrow_out, zero_out;
    logic [255:0] d_out;
    int           errors = 0, checks = 0;

    typedef struct {
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] d;
        logic         brw;
        logic         zero;
        bit           same;
    } vec_t;
    vec_t vecs[8];

    mpsub32_serial dut (
        .CLK(CLK), .RST_N(RST_N), .a_in(a_in), .b_in(b_in), .write(write),
        .start(start), .busy(busy), .ready(ready), .d_out(d_out),
        .borrow_out(borrow_out), .zero_out(zero_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [255:0] a, input logic [255:0] b,
                          input bit same, input int poke, input logic [255:0] ed,
                          input logic eb, input logic ez);
        int cnt, nb;
        @(negedge CLK);
        a_in = a; b_in = b; write = 1'b1; start = same;
        if (!same) begin
            @(negedge CLK);
            write = 1'b0; start = 1'b1;
        end
        @(negedge CLK);
        write = 1'b0; start = 1'b0;
        cnt = 0; nb = 0;
        while (!ready && cnt < 20) begin
            if (busy) nb++;
            if (cnt == poke) begin
                a_in = 256'd100; b_in = '0; write = 1'b1; start = 1'b1;
            end else begin
                write = 1'b0; start = 1'b0;
            end
            @(negedge CLK);
            cnt++;
        end
        write = 1'b0; start = 1'b0;
        chk({name, " latency"}, 256'(cnt), 256'd8);
        chk({name, " busy_cycles"}, 256'(nb), 256'd8);
        chk({name, " d_out"}, d_out, ed);
        chk({name, " borrow_out"}, 256'(borrow_out), 256'(eb));
        chk({name, " zero_out"}, 256'(zero_out), 256'(ez));
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk({name, " ready_pulse_end"}, 256'(ready), 256'd0);
        @(negedge CLK);
        chk({name, " start_in_done_dropped"}, 256'(busy), 256'd0);
    endtask

    initial begin
        vecs[0] = '{256'd5, 256'd3, 256'd2, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{256'h1_0000_0000, 256'd1, 256'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{256'd0, 256'd1, {256{1'b1}}, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{{256{1'b1}}, {256{1'b1}}, 256'd0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{256'd7, 256'd7, 256'd0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{256'h1_0000_0000_0000_0000, 256'd1, 256'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{{1'b1, 255'd0}, 256'd1, {1'b0, {255{1'b1}}}, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{256'd3, 256'd5, {{254{1'b1}}, 2'b10}, 1'b1, 1'b0, 1'b1};

        repeat (2) @(negedge CLK);
        chk("reset busy", 256'(busy), 256'd0);
        chk("reset ready", 256'(ready), 256'd0);
        chk("reset d_out", d_out, 256'd0);
        chk("reset borrow_out", 256'(borrow_out), 256'd0);
        chk("reset zero_out", 256'(zero_out), 256'd0);
        RST_N = 1'b1;

        // Start without any write runs on the reset-cleared operands.
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (8) @(negedge CLK);
        chk("nowrite ready", 256'(ready), 256'd1);
        chk("nowrite zero_out", 256'(zero_out), 256'd1);
        chk("nowrite d_out", d_out, 256'd0);
        @(negedge CLK);

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].same, -1,
                   vecs[i].d, vecs[i].brw, vecs[i].zero);

        run_op("handshake", 256'd10, 256'd4, 1'b1, 3, 256'd6, 1'b0, 1'b0);
        begin
            int extra = 0;
            repeat (12) begin
                @(negedge CLK);
                if (ready) extra++;
            end
            chk("handshake single_ready", 256'(extra), 256'd0);
            chk("handshake d_hold", d_out, 256'd6);
        end

        // Leave borrow_out=1 from an underflow so the reset clear is observable.
        run_op("pre_reset", 256'd0, 256'd1, 1'b0, -1, {256{1'b1}}, 1'b1, 1'b0);
        @(negedge CLK);
        a_in = 256'd5; b_in = 256'd3; write = 1'b1; start = 1'b1;
        @(negedge CLK);
        write = 1'b0; start = 1'b0;
        repeat (3) @(negedge CLK);
        chk("midrun busy", 256'(busy), 256'd1);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        chk("abort busy", 256'(busy), 256'd0);
        chk("abort d_out", d_out, 256'd0);
        chk("abort borrow_out", 256'(borrow_out), 256'd0);
        chk("abort zero_out", 256'(zero_out), 256'd0);
        begin
            int seen = 0;
            repeat (10) begin
                @(negedge CLK);
                if (ready || busy) seen++;
            end
            chk("abort no_ready", 256'(seen), 256'd0);
        end
        run_op("after_reset", 256'd9, 256'd2, 1'b0, -1, 256'd7, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
